// File: rtl/hfifo.sv
// hfifo: DEPTH-entry FIFO with four-phase (return-to-zero) req/ack handshakes
// on producer and consumer sides. An optional synchroniser chain sits on r_i
// and on a_o so either side may be asynchronous to clk. The d_o register is a
// holding stage in addition to the DEPTH storage entries.
module hfifo #(
   parameter int             N        = 1,
   parameter int             DEPTH    = 4,
   parameter logic [N-1:0]   RdataVal = {N{1'b0}},
   parameter int             SYNC     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       r_i,
   output logic                       a_i,
   input  logic [N-1:0]               d_i,
   output logic                       r_o,
   input  logic                       a_o,
   output logic [N-1:0]               d_o,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   localparam logic       IN_IDLE  = 1'b0;
   localparam logic       IN_ACK   = 1'b1;
   localparam logic [1:0] OUT_IDLE = 2'd0;
   localparam logic [1:0] OUT_REQ  = 2'd1;
   localparam logic [1:0] OUT_RTZ  = 2'd2;

   logic             rs;
   logic             as;
   logic             in_state;
   logic [1:0]       out_state;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [N-1:0]     mem [DEPTH];
   logic             push;
   logic             pop;

   // Pointers wrap explicitly at DEPTH-1 so any DEPTH works.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == LAST_PTR) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   generate
      if (SYNC == 0) begin : g_nosync
         assign rs = r_i;
         assign as = a_o;
      end else begin : g_sync
         logic [SYNC-1:0] r_sync;
         logic [SYNC-1:0] a_sync;
         // Shift chains bringing r_i and a_o into the clk domain.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_sync <= {SYNC{1'b0}};
               a_sync <= {SYNC{1'b0}};
            end else begin
               r_sync[0] <= r_i;
               a_sync[0] <= a_o;
               for (int i = 1; i < SYNC; i++) begin
                  r_sync[i] <= r_sync[i-1];
                  a_sync[i] <= a_sync[i-1];
               end
            end
         end
         assign rs = r_sync[SYNC-1];
         assign as = a_sync[SYNC-1];
      end
   endgenerate

   // Push/pop decisions both use the current level, so a pop never frees a
   // slot for a push at the same edge.
   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      if ((in_state == IN_IDLE) && rs && (level < DEPTH_LV)) begin
         push = 1'b1;
      end else begin
         push = 1'b0;
      end
      if ((out_state == OUT_IDLE) && (level != {LW{1'b0}})) begin
         pop = 1'b1;
      end else begin
         pop = 1'b0;
      end
   end

   // Storage write; entries are not cleared, reset only discards them via pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= d_i;
      end
   end

   // Input handshake FSM, write pointer; a_i is the state flop itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_state <= IN_IDLE;
         wptr     <= {PW{1'b0}};
      end else begin
         case (in_state)
            IN_IDLE: begin
               if (push) begin
                  wptr     <= ptr_inc(wptr);
                  in_state <= IN_ACK;
               end
            end
            IN_ACK: begin
               if (!rs) begin
                  in_state <= IN_IDLE;
               end
            end
            default: in_state <= IN_IDLE;
         endcase
      end
   end

   // Output handshake FSM, read pointer and the d_o holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_state <= OUT_IDLE;
         rptr      <= {PW{1'b0}};
         d_o       <= RdataVal;
      end else begin
         case (out_state)
            OUT_IDLE: begin
               if (pop) begin
                  d_o       <= mem[rptr];
                  rptr      <= ptr_inc(rptr);
                  out_state <= OUT_REQ;
               end
            end
            OUT_REQ: begin
               if (as) begin
                  out_state <= OUT_RTZ;
               end
            end
            OUT_RTZ: begin
               if (!as) begin
                  out_state <= OUT_IDLE;
               end
            end
            default: out_state <= OUT_IDLE;
         endcase
      end
   end

   // Occupancy of the storage array (the d_o register is not counted).
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= {LW{1'b0}};
      end else begin
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign a_i = (in_state == IN_ACK);
   assign r_o = (out_state == OUT_REQ);

endmodule

// File: tb/tb_hfifo.sv
// Bench for hfifo: instance A (DEPTH=4, SYNC=0) and instance B (DEPTH=3,
// SYNC=2). Expected tokens go into a queue when driven and are popped when the
// consumer side presents them.
module tb_hfifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       r_a_i, a_a_i, r_a_o, a_a_o;
   logic [7:0] d_a_i, d_a_o;
   logic [2:0] lvl_a;
   logic       r_b_i, a_b_i, r_b_o, a_b_o;
   logic [7:0] d_b_i, d_b_o;
   logic [1:0] lvl_b;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb_a[$];
   logic [7:0] sb_b[$];

   always #5 clk = ~clk;

   hfifo #(.N(8), .DEPTH(4), .RdataVal(8'h5A), .SYNC(0)) dut_a (
      .clk(clk), .rst(rst), .r_i(r_a_i), .a_i(a_a_i), .d_i(d_a_i),
      .r_o(r_a_o), .a_o(a_a_o), .d_o(d_a_o), .level(lvl_a));

   hfifo #(.N(8), .DEPTH(3), .RdataVal(8'h3C), .SYNC(2)) dut_b (
      .clk(clk), .rst(rst), .r_i(r_b_i), .a_i(a_b_i), .d_i(d_b_i),
      .r_o(r_b_o), .a_o(a_b_o), .d_o(d_b_o), .level(lvl_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Producer handshake on A; records the token as expected output.
   task automatic put_a(input logic [7:0] v, output bit ok);
      int n;
      d_a_i = v;
      r_a_i = 1'b1;
      sb_a.push_back(v);
      n = 0;
      while (a_a_i !== 1'b1 && n < 40) begin tick(); n++; end
      ok = (a_a_i === 1'b1);
      r_a_i = 1'b0;
      n = 0;
      while (a_a_i !== 1'b0 && n < 40) begin tick(); n++; end
      ok = ok && (a_a_i === 1'b0);
   endtask

   // Consumer handshake on A; returns the presented token.
   task automatic take_a(output logic [7:0] v, output bit ok);
      int n;
      n = 0;
      while (r_a_o !== 1'b1 && n < 40) begin tick(); n++; end
      ok = (r_a_o === 1'b1);
      v = d_a_o;
      a_a_o = 1'b1;
      n = 0;
      while (r_a_o !== 1'b0 && n < 40) begin tick(); n++; end
      ok = ok && (r_a_o === 1'b0);
      a_a_o = 1'b0;
      tick();
   endtask

   task automatic put_b(input logic [7:0] v, output bit ok);
      int n;
      d_b_i = v;
      r_b_i = 1'b1;
      sb_b.push_back(v);
      n = 0;
      while (a_b_i !== 1'b1 && n < 40) begin tick(); n++; end
      ok = (a_b_i === 1'b1);
      r_b_i = 1'b0;
      n = 0;
      while (a_b_i !== 1'b0 && n < 40) begin tick(); n++; end
      ok = ok && (a_b_i === 1'b0);
   endtask

   task automatic take_b(output logic [7:0] v, output bit ok);
      int n;
      n = 0;
      while (r_b_o !== 1'b1 && n < 60) begin tick(); n++; end
      ok = (r_b_o === 1'b1);
      v = d_b_o;
      repeat ($urandom_range(0, 3)) tick();
      a_b_o = 1'b1;
      n = 0;
      while (r_b_o !== 1'b0 && n < 60) begin tick(); n++; end
      ok = ok && (r_b_o === 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      a_b_o = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      r_a_i = 1'($urandom); a_a_o = 1'($urandom); d_a_i = 8'($urandom);
      r_b_i = 1'($urandom); a_b_o = 1'($urandom); d_b_i = 8'($urandom);
      tick(); tick();
      checks += 8;
      if (a_a_i !== 1'b0) begin errors++; $display("FAIL reset_a_i got %b exp 0", a_a_i); end
      if (r_a_o !== 1'b0) begin errors++; $display("FAIL reset_r_o got %b exp 0", r_a_o); end
      if (d_a_o !== 8'h5A) begin errors++; $display("FAIL reset_d_o got %h exp 5a", d_a_o); end
      if (lvl_a !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", lvl_a); end
      if (a_b_i !== 1'b0) begin errors++; $display("FAIL reset_b_a_i got %b exp 0", a_b_i); end
      if (r_b_o !== 1'b0) begin errors++; $display("FAIL reset_b_r_o got %b exp 0", r_b_o); end
      if (d_b_o !== 8'h3C) begin errors++; $display("FAIL reset_b_d_o got %h exp 3c", d_b_o); end
      if (lvl_b !== 2'd0) begin errors++; $display("FAIL reset_b_level got %0d exp 0", lvl_b); end
      r_a_i = 1'b0; a_a_o = 1'b0; r_b_i = 1'b0; a_b_o = 1'b0;
      rst = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_single();
      logic [7:0] e;
      d_a_i = 8'hA5;
      r_a_i = 1'b1;
      sb_a.push_back(8'hA5);
      tick();
      checks += 3;
      if (a_a_i !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp 1", a_a_i); end
      if (lvl_a !== 3'd1) begin errors++; $display("FAIL single_lvl1 got %0d exp 1", lvl_a); end
      if (r_a_o !== 1'b0) begin errors++; $display("FAIL single_ro_early got %b exp 0", r_a_o); end
      r_a_i = 1'b0;
      tick();
      e = sb_a.pop_front();
      checks += 3;
      if (r_a_o !== 1'b1) begin errors++; $display("FAIL single_req got %b exp 1", r_a_o); end
      if (d_a_o !== e) begin errors++; $display("FAIL single_data got %h exp %h", d_a_o, e); end
      if (lvl_a !== 3'd0) begin errors++; $display("FAIL single_lvl0 got %0d exp 0", lvl_a); end
      a_a_o = 1'b1;
      tick();
      checks++;
      if (r_a_o !== 1'b0) begin errors++; $display("FAIL single_rtz got %b exp 0", r_a_o); end
      a_a_o = 1'b0;
      tick(); tick();
      checks += 2;
      if (r_a_o !== 1'b0) begin errors++; $display("FAIL single_empty_ro got %b exp 0", r_a_o); end
      if (d_a_o !== 8'hA5) begin errors++; $display("FAIL single_hold got %h exp a5", d_a_o); end
   endtask

   task automatic test_full();
      bit ok;
      int n;
      logic [7:0] v, e;
      for (int i = 1; i <= 5; i++) begin
         put_a(8'(i), ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL full_put%0d timeout got 0 exp 1", i); end
      end
      d_a_i = 8'd6;
      r_a_i = 1'b1;
      sb_a.push_back(8'd6);
      tick(); tick(); tick();
      checks += 4;
      if (a_a_i !== 1'b0) begin errors++; $display("FAIL full_backpressure got %b exp 0", a_a_i); end
      if (lvl_a !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", lvl_a); end
      if (d_a_o !== 8'd1) begin errors++; $display("FAIL full_dout got %h exp 01", d_a_o); end
      if (r_a_o !== 1'b1) begin errors++; $display("FAIL full_req got %b exp 1", r_a_o); end
      take_a(v, ok);
      e = sb_a.pop_front();
      checks++;
      if (!ok || v !== e) begin errors++; $display("FAIL full_first got %h exp %h", v, e); end
      n = 0;
      while (a_a_i !== 1'b1 && n < 40) begin tick(); n++; end
      checks++;
      if (a_a_i !== 1'b1) begin errors++; $display("FAIL full_sixth_ack got %b exp 1", a_a_i); end
      r_a_i = 1'b0;
      n = 0;
      while (a_a_i !== 1'b0 && n < 40) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         take_a(v, ok);
         e = sb_a.pop_front();
         checks++;
         if (!ok || v !== e) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, v, e); end
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      logic [7:0] v, e;
      put_a(8'd10, ok);
      put_a(8'd11, ok);
      put_a(8'd12, ok);
      tick();
      e = sb_a.pop_front();
      checks += 3;
      if (lvl_a !== 3'd2) begin errors++; $display("FAIL simul_setup got %0d exp 2", lvl_a); end
      if (r_a_o !== 1'b1) begin errors++; $display("FAIL simul_req got %b exp 1", r_a_o); end
      if (d_a_o !== e) begin errors++; $display("FAIL simul_head got %h exp %h", d_a_o, e); end
      a_a_o = 1'b1;
      tick();
      a_a_o = 1'b0;
      tick();
      d_a_i = 8'd13;
      r_a_i = 1'b1;
      sb_a.push_back(8'd13);
      tick();
      checks += 3;
      if (lvl_a !== 3'd2) begin errors++; $display("FAIL simul_level got %0d exp 2", lvl_a); end
      if (a_a_i !== 1'b1) begin errors++; $display("FAIL simul_ack got %b exp 1", a_a_i); end
      if (r_a_o !== 1'b1) begin errors++; $display("FAIL simul_pop got %b exp 1", r_a_o); end
      r_a_i = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         take_a(v, ok);
         e = sb_a.pop_front();
         checks++;
         if (!ok || v !== e) begin errors++; $display("FAIL simul_order%0d got %h exp %h", i, v, e); end
      end
   endtask

   task automatic test_wrap_sync();
      bit ok;
      int n;
      logic [7:0] v, e;
      d_b_i = 8'd0;
      r_b_i = 1'b1;
      sb_b.push_back(8'd0);
      n = 0;
      while (a_b_i !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL sync_latency got %0d exp 3", n); end
      r_b_i = 1'b0;
      n = 0;
      while (a_b_i !== 1'b0 && n < 20) begin tick(); n++; end
      fork
         begin
            bit pok;
            for (int i = 1; i < 10; i++) begin
               put_b(8'(i), pok);
               checks++;
               if (!pok) begin errors++; $display("FAIL sync_put%0d timeout got 0 exp 1", i); end
            end
         end
         begin
            bit cok;
            logic [7:0] cv, ce;
            for (int i = 0; i < 10; i++) begin
               take_b(cv, cok);
               ce = (sb_b.size() > 0) ? sb_b.pop_front() : 8'hFF;
               checks++;
               if (!cok || cv !== ce) begin errors++; $display("FAIL sync_order%0d got %h exp %h", i, cv, ce); end
            end
         end
      join
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [7:0] v, e;
      for (int i = 20; i < 24; i++) put_a(8'(i), ok);
      tick();
      checks += 2;
      if (lvl_a !== 3'd3) begin errors++; $display("FAIL mid_setup got %0d exp 3", lvl_a); end
      if (r_a_o !== 1'b1) begin errors++; $display("FAIL mid_req got %b exp 1", r_a_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb_a.delete();
      checks += 4;
      if (a_a_i !== 1'b0) begin errors++; $display("FAIL mid_a_i got %b exp 0", a_a_i); end
      if (r_a_o !== 1'b0) begin errors++; $display("FAIL mid_r_o got %b exp 0", r_a_o); end
      if (d_a_o !== 8'h5A) begin errors++; $display("FAIL mid_d_o got %h exp 5a", d_a_o); end
      if (lvl_a !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", lvl_a); end
      put_a(8'd30, ok);
      take_a(v, ok);
      e = sb_a.pop_front();
      checks++;
      if (!ok || v !== e) begin errors++; $display("FAIL mid_token got %h exp %h", v, e); end
      tick(); tick(); tick();
      checks += 2;
      if (r_a_o !== 1'b0) begin errors++; $display("FAIL mid_alone got %b exp 0", r_a_o); end
      if (lvl_a !== 3'd0) begin errors++; $display("FAIL mid_empty got %0d exp 0", lvl_a); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_simultaneous();
      test_wrap_sync();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
